instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of program_memory. Owns the PC and drives the word address to the

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_queue.sv | 53 +++++
 rtl/instruction_fetch.sv | 92 +++++++++
 tb/tb_instruction_fetch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC, fetch packet and fetch state.
package cpu_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    // RUN allows new fetches; HALTED lets in-flight and buffered words drain.
    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

    // Sequential fetch address; wraps naturally at 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetch packets. Flush overrides push and pop.
module fetch_queue
    import cpu_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  fetch_pkt_t i_data,
    output logic [1:0] o_count,
    output fetch_pkt_t o_head
);

    fetch_pkt_t r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    // Storage, pointers and occupancy; reset also clears storage so the head reads zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            assert (!(i_push && (r_count == 2'd2)));
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and hands
// {pc, instr} to decode through a two-entry queue with valid/ready.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    logic [31:0]  r_pc;
    logic         r_inflight;
    logic [31:0]  r_inflight_pc;

    fetch_state_e w_state;
    logic [1:0]   w_count;
    fetch_pkt_t   w_head;
    fetch_pkt_t   w_push_data;
    logic         w_pop;
    logic         w_push;
    logic         w_issue;
    logic [2:0]   w_occupancy;
    logic [31:0]  w_redirect_aligned;

    assign w_redirect_aligned = redirect_pc & ~32'(INSTR_BYTES - 1);

    assign instr_valid = (w_count != 2'd0);
    assign w_pop       = instr_valid & instr_ready & ~redirect_valid;
    // A word landing in the same cycle as a redirect belongs to the old stream.
    assign w_push      = r_inflight & ~redirect_valid;
    assign w_push_data = '{pc: r_inflight_pc, instr: imem_rdata};

    // Credit check counts queued words plus the one in flight, minus the one leaving.
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight};

    // Halt decode and issue decision; redirect outranks halt and pop.
    always_comb begin
        w_state = FETCH_RUN;
        w_issue = 1'b0;
        if (halt) begin
            w_state = FETCH_HALTED;
        end
        if (!rst && !redirect_valid && (w_state == FETCH_RUN)) begin
            w_issue = (w_occupancy < (3'(BUF_DEPTH) + {2'b00, w_pop}));
        end
    end

    // PC and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_pc          <= w_redirect_aligned;
            r_inflight    <= 1'b0;
        end else if (w_issue) begin
            r_pc          <= next_pc(r_pc);
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
        end else begin
            r_inflight    <= 1'b0;
        end
    end

    fetch_queue u_queue (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_data),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign imem_addr = r_pc;
    assign instr     = w_head.instr;
    assign instr_pc  = w_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory returns addr>>2, so instr == instr_pc>>2.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb[$];

    instruction_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    // Registered memory with one cycle of read latency.
    always @(posedge clk) imem_rdata <= imem_addr >> 2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sb_load(input logic [31:0] start);
        sb.delete();
        for (int i = 0; i < 48; i++) sb.push_back(start + 32'(4 * i));
    endtask

    // One cycle: drive just after the edge, return at the following negedge.
    task automatic drive(input logic r, input logic h, input logic rv,
                         input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        rst = r; halt = h; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
        if (r) sb_load(32'h0000_0000);
        else if (rv) sb_load(rpc & 32'hFFFF_FFFC);
        @(negedge clk);
    endtask

    // Scoreboard consumer and head-stability monitor.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc, prev_instr;
    always @(negedge clk) begin
        if (prev_hold) begin
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("hold_pc", instr_pc, prev_pc);
            chk("hold_instr", instr, prev_instr);
        end
        prev_hold  = instr_valid & ~instr_ready & ~rst & ~redirect_valid;
        prev_pc    = instr_pc;
        prev_instr = instr;
        if (instr_valid && instr_ready && !rst && !redirect_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("sb_pc", instr_pc, e);
                chk("sb_instr", instr, e >> 2);
            end
        end
    end

    typedef struct {
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] a0;

        // Cycles 0..11 after reset: latency, then backpressure in cycles 3-8.
        tbl[0]  = '{1'b1, 1'b0, 32'h0, 32'd0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0, 32'd4};
        tbl[2]  = '{1'b1, 1'b1, 32'd0, 32'd8};
        tbl[3]  = '{1'b0, 1'b1, 32'd4, 32'd12};
        tbl[4]  = '{1'b0, 1'b1, 32'd4, 32'd12};
        tbl[5]  = '{1'b0, 1'b1, 32'd4, 32'd12};
        tbl[6]  = '{1'b0, 1'b1, 32'd4, 32'd12};
        tbl[7]  = '{1'b0, 1'b1, 32'd4, 32'd12};
        tbl[8]  = '{1'b0, 1'b1, 32'd4, 32'd12};
        tbl[9]  = '{1'b1, 1'b1, 32'd4, 32'd12};
        tbl[10] = '{1'b1, 1'b1, 32'd8, 32'd16};
        tbl[11] = '{1'b1, 1'b1, 32'd12, 32'd20};

        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, tbl[c].rdy);
            if (c == 0) begin
                chk("rst_instr", instr, 32'h0);
                chk("rst_instr_pc", instr_pc, 32'h0);
            end
            chk("tbl_valid", {31'b0, instr_valid}, {31'b0, tbl[c].exp_valid});
            chk("tbl_addr", imem_addr, tbl[c].exp_addr);
            if (tbl[c].exp_valid) begin
                chk("tbl_pc", instr_pc, tbl[c].exp_pc);
                chk("tbl_instr", instr, tbl[c].exp_pc >> 2);
            end
        end

        // Redirect to 0x100 while a word is in flight and backpressure fills the queue.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_r1_valid", {31'b0, instr_valid}, 32'd0);
        chk("redir_r1_addr", imem_addr, 32'h100);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_r2_valid", {31'b0, instr_valid}, 32'd0);
        chk("redir_r2_addr", imem_addr, 32'h104);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_r3_valid", {31'b0, instr_valid}, 32'd1);
        chk("redir_r3_pc", instr_pc, 32'h100);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Halt for five cycles: drain, then resume at the next address.
        a0 = '0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            if (i == 0) a0 = imem_addr;
            else chk("halt_addr", imem_addr, a0);
            if (i >= 3) chk("halt_drained", {31'b0, instr_valid}, 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("resume_addr", imem_addr, a0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("resume_d1_valid", {31'b0, instr_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("resume_d2_valid", {31'b0, instr_valid}, 32'd1);
        chk("resume_pc", instr_pc, a0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Unaligned redirect together with halt.
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            chk("rh_addr", imem_addr, 32'h100);
            chk("rh_valid", {31'b0, instr_valid}, 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("rh_d1_valid", {31'b0, instr_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("rh_d2_valid", {31'b0, instr_valid}, 32'd1);
        chk("rh_pc", instr_pc, 32'h100);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Address wrap past 32'hFFFF_FFFC.
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_r2_addr", imem_addr, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_r3_addr", imem_addr, 32'h0);
        chk("wrap_r3_pc", instr_pc, 32'hFFFF_FFF8);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_r4_pc", instr_pc, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_r5_pc", instr_pc, 32'h0);
        chk("wrap_r5_instr", instr, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // One-cycle reset mid-stream.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_instr", instr, 32'h0);
        chk("mrst_instr_pc", instr_pc, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("mrst_c1_valid", {31'b0, instr_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("mrst_c2_valid", {31'b0, instr_valid}, 32'd1);
        chk("mrst_c2_pc", instr_pc, 32'h0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
